lin_ahb_arbiter: RTL

//  Bus arbiter for the lin_ahb fabric. Samples hbusreq/hlock from up to NUM_MST masters and drives
//  one-hot hgrant. Drives hmaster/hmastlock to the address/data mux and to the slaves.

---
 rtl/lin_ahb_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lin_ahb_arbiter.sv
// AHB bus arbiter: round-robin (or fixed-priority with LIN_AHB_ARB_FIXED_PRIO_EN) grant,
// with handover only at burst ends, after locked sequences and after RETRY/SPLIT.
module lin_ahb_arbiter #(
    parameter int unsigned NUM_MST     = 4,
    parameter int unsigned DEFAULT_MST = 0,
    localparam int unsigned MW         = $clog2(NUM_MST)
) (
    input  logic               hclk,
    input  logic               hresetn,
    input  logic [NUM_MST-1:0] hbusreq,
    input  logic [NUM_MST-1:0] hlock,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hburst,
    input  logic               hready,
    input  logic [1:0]         hresp,
    output logic [NUM_MST-1:0] hgrant,
    output logic [MW-1:0]      hmaster,
    output logic               hmastlock
);

    localparam int unsigned CW = 4;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [1:0] RESP_RETRY = 2'd2;
    localparam logic [1:0] RESP_SPLIT = 2'd3;

    localparam logic [2:0] BU_WRAP4  = 3'd2;
    localparam logic [2:0] BU_INCR4  = 3'd3;
    localparam logic [2:0] BU_WRAP8  = 3'd4;
    localparam logic [2:0] BU_INCR8  = 3'd5;
    localparam logic [2:0] BU_WRAP16 = 3'd6;
    localparam logic [2:0] BU_INCR16 = 3'd7;

    localparam logic [NUM_MST-1:0] DEF_GRANT  = NUM_MST'(1) << DEFAULT_MST;
    localparam logic [MW-1:0]      DEF_MASTER = MW'(DEFAULT_MST);

    typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;

    state_t             state, state_d;
    logic [CW-1:0]      beat_cnt, beat_cnt_d;
    logic [CW-1:0]      burst_len;
    logic               fixed_burst;
    logic               nonseq_acc, start_lock, start_burst;
    logic               grant_en;
    logic [MW-1:0]      winner, gidx;
    logic               win_valid;
    logic [NUM_MST-1:0] grant_d;

    // Beats-1 for fixed-length bursts; SINGLE and INCR never load the counter
    always_comb begin
        burst_len   = '0;
        fixed_burst = 1'b0;
        case (hburst)
            BU_WRAP4, BU_INCR4:   begin burst_len = CW'(3);  fixed_burst = 1'b1; end
            BU_WRAP8, BU_INCR8:   begin burst_len = CW'(7);  fixed_burst = 1'b1; end
            BU_WRAP16, BU_INCR16: begin burst_len = CW'(15); fixed_burst = 1'b1; end
            default:              begin burst_len = '0;      fixed_burst = 1'b0; end
        endcase
    end

    assign nonseq_acc  = hready && (htrans == TR_NONSEQ);
    assign start_lock  = nonseq_acc && hlock[hmaster];
    assign start_burst = nonseq_acc && fixed_burst;

    // Index of the currently granted master
    always_comb begin
        gidx = DEF_MASTER;
        for (int i = 0; i < int'(NUM_MST); i++) begin
            if (hgrant[MW'(i)]) gidx = MW'(i);
        end
    end

`ifdef LIN_AHB_ARB_FIXED_PRIO_EN
    // Lowest-index requester wins; descending scan leaves the lowest index last
    always_comb begin
        winner    = DEF_MASTER;
        win_valid = 1'b0;
        for (int i = int'(NUM_MST) - 1; i >= 0; i--) begin
            if (hbusreq[MW'(i)]) begin
                winner    = MW'(i);
                win_valid = 1'b1;
            end
        end
    end
`else
    logic [MW-1:0] rr_ptr;
    int unsigned   rr_idx;

    // Search from rr_ptr+1 with wrap; descending offset leaves the nearest requester last
    always_comb begin
        winner    = DEF_MASTER;
        win_valid = 1'b0;
        rr_idx    = 0;
        for (int i = int'(NUM_MST); i >= 1; i--) begin
            rr_idx = (int'(rr_ptr) + i) % NUM_MST;
            if (hbusreq[MW'(rr_idx)]) begin
                winner    = MW'(rr_idx);
                win_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rr_ptr <= DEF_MASTER;
        end else if (grant_en && win_valid) begin
            rr_ptr <= winner;
        end
    end
`endif

    always_comb begin
        grant_d         = '0;
        grant_d[winner] = 1'b1;
    end

    // Next state, burst counter and arbitration window
    always_comb begin
        state_d    = state;
        beat_cnt_d = beat_cnt;
        grant_en   = 1'b0;
        case (state)
            ARB: begin
                // The edge that starts a burst or locked sequence keeps the current grant
                grant_en = hready && !start_lock && !start_burst;
                if (start_lock) begin
                    state_d = LOCKED;
                end else if (start_burst) begin
                    state_d    = BURST;
                    beat_cnt_d = burst_len;
                end
            end
            BURST: begin
                grant_en = hready && (beat_cnt == CW'(1));
                if (hready && (beat_cnt == '0)) begin
                    if (start_lock) begin
                        state_d = LOCKED;
                    end else if (start_burst) begin
                        state_d    = BURST;
                        beat_cnt_d = burst_len;
                    end else begin
                        state_d = ARB;
                    end
                end else if (htrans == TR_IDLE) begin
                    state_d    = ARB;
                    beat_cnt_d = '0;
                end else if (hready && (htrans == TR_SEQ)) begin
                    beat_cnt_d = beat_cnt - CW'(1);
                end
            end
            LOCKED: begin
                if (hready && (htrans == TR_NONSEQ || htrans == TR_SEQ) && !hlock[hmaster]) begin
                    state_d = ARB;
                end
            end
            default: begin
                state_d    = ARB;
                beat_cnt_d = '0;
            end
        endcase
        // First RETRY/SPLIT cycle reopens arbitration so the grant moves on the second
        if (!hready && (hresp == RESP_RETRY || hresp == RESP_SPLIT)) begin
            state_d    = ARB;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= ARB;
            beat_cnt <= '0;
        end else begin
            state    <= state_d;
            beat_cnt <= beat_cnt_d;
        end
    end

    // Grant register and address-phase ownership
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hgrant    <= DEF_GRANT;
            hmaster   <= DEF_MASTER;
            hmastlock <= 1'b0;
        end else begin
            if (grant_en) hgrant <= grant_d;
            if (hready) begin
                hmaster   <= gidx;
                hmastlock <= hlock[gidx];
            end
        end
    end

endmodule
